// File: rtl/merge16_scheduler.sv
// merge16_scheduler
//   Reduces four priority-sorted groups of 8 clusters (A..D) to one group of
//   8 by time-multiplexing a single external merge16_light on clock4x:
//   A+B, then C+D, then AB+CD. The merger returns no valid flags, so counts
//   are tracked here and unused result slots are zero-filled.
// Ports
//   clock4x, reset_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready         : frame handshake; in_adr/in_cnt/in_vpf carry
//                               group g slot s at index g*8+s
//   m_adr/cnt/vpf_lo/hi,
//   m_mux_pulse               : issue side of the shared merger
//   m_adr_o, m_cnt_o,
//   m_mux_pulse_o             : merger results and return strobe
//   out_valid, out_adr,
//   out_cnt, out_vpf,
//   out_ncl, out_trunc        : merged result (held between frames)
//   drop_cnt                  : saturating count of frames offered while busy
//   err_vpf, err_sync         : sticky non-thermometer vpf / missing return pulse
module merge16_scheduler #(
  parameter int MXADRBITS = 11,
  parameter int MXCNTBITS = 3
) (
  input  logic                      clock4x,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [32*MXADRBITS-1:0]   in_adr,
  input  logic [32*MXCNTBITS-1:0]   in_cnt,
  input  logic [31:0]               in_vpf,
  output logic [8*MXADRBITS-1:0]    m_adr_lo,
  output logic [8*MXADRBITS-1:0]    m_adr_hi,
  output logic [8*MXCNTBITS-1:0]    m_cnt_lo,
  output logic [8*MXCNTBITS-1:0]    m_cnt_hi,
  output logic [7:0]                m_vpf_lo,
  output logic [7:0]                m_vpf_hi,
  output logic                      m_mux_pulse,
  input  logic [8*MXADRBITS-1:0]    m_adr_o,
  input  logic [8*MXCNTBITS-1:0]    m_cnt_o,
  input  logic                      m_mux_pulse_o,
  output logic                      out_valid,
  output logic [8*MXADRBITS-1:0]    out_adr,
  output logic [8*MXCNTBITS-1:0]    out_cnt,
  output logic [7:0]                out_vpf,
  output logic [3:0]                out_ncl,
  output logic                      out_trunc,
  output logic [7:0]                drop_cnt,
  output logic                      err_vpf,
  output logic                      err_sync
);

  localparam int AW = 8*MXADRBITS;
  localparam int CW = 8*MXCNTBITS;

  typedef enum logic [3:0] {
    S_IDLE, S_ISS_AB, S_ISS_CD, S_WAIT, S_CAP_AB, S_CAP_CD, S_W1, S_W2, S_CAP_F
  } state_t;

  function automatic logic [3:0] lead_ones(input logic [7:0] v);
    logic [3:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (run && v[i]) n = n + 4'd1;
      else             run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [7:0] therm(input logic [3:0] n);
    logic [7:0] t;
    t = '0;
    for (int unsigned i = 0; i < 8; i++) t[i] = (i < 32'(n));
    return t;
  endfunction

  function automatic logic [3:0] min8(input logic [5:0] s);
    return (s > 6'd8) ? 4'd8 : s[3:0];
  endfunction

  function automatic logic [AW-1:0] mask_adr(input logic [AW-1:0] a, input logic [3:0] n);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned s = 0; s < 8; s++)
      if (s < 32'(n)) r[s*MXADRBITS +: MXADRBITS] = a[s*MXADRBITS +: MXADRBITS];
    return r;
  endfunction

  function automatic logic [CW-1:0] mask_cnt(input logic [CW-1:0] c, input logic [3:0] n);
    logic [CW-1:0] r;
    r = '0;
    for (int unsigned s = 0; s < 8; s++)
      if (s < 32'(n)) r[s*MXCNTBITS +: MXCNTBITS] = c[s*MXCNTBITS +: MXCNTBITS];
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic [32*MXADRBITS-1:0] grp_adr_q, grp_adr_d;
  logic [32*MXCNTBITS-1:0] grp_cnt_q, grp_cnt_d;
  logic [3:0][3:0]         n_q, n_d;
  logic [AW-1:0]           ab_adr_q, ab_adr_d;
  logic [CW-1:0]           ab_cnt_q, ab_cnt_d;
  logic [AW-1:0]           m_adr_lo_q, m_adr_lo_d, m_adr_hi_q, m_adr_hi_d;
  logic [CW-1:0]           m_cnt_lo_q, m_cnt_lo_d, m_cnt_hi_q, m_cnt_hi_d;
  logic [7:0]              m_vpf_lo_q, m_vpf_lo_d, m_vpf_hi_q, m_vpf_hi_d;
  logic                    m_mux_pulse_q, m_mux_pulse_d;
  logic                    out_valid_q, out_valid_d;
  logic [AW-1:0]           out_adr_q, out_adr_d;
  logic [CW-1:0]           out_cnt_q, out_cnt_d;
  logic [7:0]              out_vpf_q, out_vpf_d;
  logic [3:0]              out_ncl_q, out_ncl_d;
  logic                    out_trunc_q, out_trunc_d;
  logic [7:0]              drop_q, drop_d;
  logic                    err_vpf_q, err_vpf_d;
  logic                    err_sync_q, err_sync_d;

  logic                    accept;
  logic [3:0]              n_ab, n_cd, n_f;
  logic [5:0]              n_tot;
  logic                    issue, swap;
  logic [AW-1:0]           op_l_adr, op_h_adr;
  logic [CW-1:0]           op_l_cnt, op_h_cnt;
  logic [3:0]              op_l_n, op_h_n;

  assign accept = in_valid & in_ready_q;
  assign n_ab   = min8(6'(n_q[0]) + 6'(n_q[1]));
  assign n_cd   = min8(6'(n_q[2]) + 6'(n_q[3]));
  assign n_f    = min8(6'(n_ab) + 6'(n_cd));
  assign n_tot  = 6'(n_q[0]) + 6'(n_q[1]) + 6'(n_q[2]) + 6'(n_q[3]);

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      grp_adr_q     <= '0;
      grp_cnt_q     <= '0;
      n_q           <= '0;
      ab_adr_q      <= '0;
      ab_cnt_q      <= '0;
      m_adr_lo_q    <= '0;
      m_adr_hi_q    <= '0;
      m_cnt_lo_q    <= '0;
      m_cnt_hi_q    <= '0;
      m_vpf_lo_q    <= '0;
      m_vpf_hi_q    <= '0;
      m_mux_pulse_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_adr_q     <= '0;
      out_cnt_q     <= '0;
      out_vpf_q     <= '0;
      out_ncl_q     <= '0;
      out_trunc_q   <= 1'b0;
      drop_q        <= '0;
      err_vpf_q     <= 1'b0;
      err_sync_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      grp_adr_q     <= grp_adr_d;
      grp_cnt_q     <= grp_cnt_d;
      n_q           <= n_d;
      ab_adr_q      <= ab_adr_d;
      ab_cnt_q      <= ab_cnt_d;
      m_adr_lo_q    <= m_adr_lo_d;
      m_adr_hi_q    <= m_adr_hi_d;
      m_cnt_lo_q    <= m_cnt_lo_d;
      m_cnt_hi_q    <= m_cnt_hi_d;
      m_vpf_lo_q    <= m_vpf_lo_d;
      m_vpf_hi_q    <= m_vpf_hi_d;
      m_mux_pulse_q <= m_mux_pulse_d;
      out_valid_q   <= out_valid_d;
      out_adr_q     <= out_adr_d;
      out_cnt_q     <= out_cnt_d;
      out_vpf_q     <= out_vpf_d;
      out_ncl_q     <= out_ncl_d;
      out_trunc_q   <= out_trunc_d;
      drop_q        <= drop_d;
      err_vpf_q     <= err_vpf_d;
      err_sync_q    <= err_sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ISS_AB;
      S_ISS_AB: state_d = S_ISS_CD;
      S_ISS_CD: state_d = S_WAIT;
      S_WAIT:   state_d = S_CAP_AB;
      S_CAP_AB: state_d = S_CAP_CD;
      S_CAP_CD: state_d = S_W1;
      S_W1:     state_d = S_W2;
      S_W2:     state_d = S_CAP_F;
      S_CAP_F:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Operand selection for the three merges. In CAP_CD the CD result is
  // taken straight off the merger, masked to its count, and reissued.
  always_comb begin
    issue    = 1'b0;
    op_l_adr = '0;
    op_l_cnt = '0;
    op_l_n   = '0;
    op_h_adr = '0;
    op_h_cnt = '0;
    op_h_n   = '0;
    case (state_q)
      S_ISS_AB: begin
        issue    = 1'b1;
        op_l_adr = grp_adr_q[0*AW +: AW];
        op_l_cnt = grp_cnt_q[0*CW +: CW];
        op_l_n   = n_q[0];
        op_h_adr = grp_adr_q[1*AW +: AW];
        op_h_cnt = grp_cnt_q[1*CW +: CW];
        op_h_n   = n_q[1];
      end
      S_ISS_CD: begin
        issue    = 1'b1;
        op_l_adr = grp_adr_q[2*AW +: AW];
        op_l_cnt = grp_cnt_q[2*CW +: CW];
        op_l_n   = n_q[2];
        op_h_adr = grp_adr_q[3*AW +: AW];
        op_h_cnt = grp_cnt_q[3*CW +: CW];
        op_h_n   = n_q[3];
      end
      S_CAP_CD: begin
        issue    = 1'b1;
        op_l_adr = ab_adr_q;
        op_l_cnt = ab_cnt_q;
        op_l_n   = n_ab;
        op_h_adr = mask_adr(m_adr_o, n_cd);
        op_h_cnt = mask_cnt(m_cnt_o, n_cd);
        op_h_n   = n_cd;
      end
      default: ;
    endcase
    // Fuller operand goes to the lo port so an empty lo half never stalls
    // the merger; ties keep L on lo to preserve group priority.
    swap = (op_h_n > op_l_n);
  end

  always_comb begin
    grp_adr_d     = grp_adr_q;
    grp_cnt_d     = grp_cnt_q;
    n_d           = n_q;
    ab_adr_d      = ab_adr_q;
    ab_cnt_d      = ab_cnt_q;
    m_adr_lo_d    = m_adr_lo_q;
    m_adr_hi_d    = m_adr_hi_q;
    m_cnt_lo_d    = m_cnt_lo_q;
    m_cnt_hi_d    = m_cnt_hi_q;
    m_vpf_lo_d    = m_vpf_lo_q;
    m_vpf_hi_d    = m_vpf_hi_q;
    m_mux_pulse_d = 1'b0;
    out_valid_d   = 1'b0;
    out_adr_d     = out_adr_q;
    out_cnt_d     = out_cnt_q;
    out_vpf_d     = out_vpf_q;
    out_ncl_d     = out_ncl_q;
    out_trunc_d   = out_trunc_q;
    err_vpf_d     = err_vpf_q;
    err_sync_d    = err_sync_q;
    drop_d        = drop_q;
    in_ready_d    = (state_d == S_IDLE);

    if (in_valid && !in_ready_q && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          grp_adr_d = in_adr;
          grp_cnt_d = in_cnt;
          for (int unsigned g = 0; g < 4; g++) begin
            n_d[g] = lead_ones(in_vpf[g*8 +: 8]);
            if (in_vpf[g*8 +: 8] != therm(lead_ones(in_vpf[g*8 +: 8]))) err_vpf_d = 1'b1;
          end
        end
      end
      S_CAP_AB: begin
        ab_adr_d = mask_adr(m_adr_o, n_ab);
        ab_cnt_d = mask_cnt(m_cnt_o, n_ab);
        if (!m_mux_pulse_o) err_sync_d = 1'b1;
      end
      S_CAP_CD: begin
        if (!m_mux_pulse_o) err_sync_d = 1'b1;
      end
      S_CAP_F: begin
        out_adr_d   = mask_adr(m_adr_o, n_f);
        out_cnt_d   = mask_cnt(m_cnt_o, n_f);
        out_vpf_d   = therm(n_f);
        out_ncl_d   = n_f;
        out_trunc_d = (n_tot > 6'd8);
        out_valid_d = 1'b1;
        if (!m_mux_pulse_o) err_sync_d = 1'b1;
      end
      default: ;
    endcase

    if (issue) begin
      m_mux_pulse_d = 1'b1;
      if (swap) begin
        m_adr_lo_d = op_h_adr;
        m_cnt_lo_d = op_h_cnt;
        m_vpf_lo_d = therm(op_h_n);
        m_adr_hi_d = op_l_adr;
        m_cnt_hi_d = op_l_cnt;
        m_vpf_hi_d = therm(op_l_n);
      end else begin
        m_adr_lo_d = op_l_adr;
        m_cnt_lo_d = op_l_cnt;
        m_vpf_lo_d = therm(op_l_n);
        m_adr_hi_d = op_h_adr;
        m_cnt_hi_d = op_h_cnt;
        m_vpf_hi_d = therm(op_h_n);
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign m_adr_lo    = m_adr_lo_q;
  assign m_adr_hi    = m_adr_hi_q;
  assign m_cnt_lo    = m_cnt_lo_q;
  assign m_cnt_hi    = m_cnt_hi_q;
  assign m_vpf_lo    = m_vpf_lo_q;
  assign m_vpf_hi    = m_vpf_hi_q;
  assign m_mux_pulse = m_mux_pulse_q;
  assign out_valid   = out_valid_q;
  assign out_adr     = out_adr_q;
  assign out_cnt     = out_cnt_q;
  assign out_vpf     = out_vpf_q;
  assign out_ncl     = out_ncl_q;
  assign out_trunc   = out_trunc_q;
  assign drop_cnt    = drop_q;
  assign err_vpf     = err_vpf_q;
  assign err_sync    = err_sync_q;

endmodule

// File: tb/tb_merge16_scheduler.sv
// Bench for merge16_scheduler: a two-stage merger stub (valid lo entries,
// then valid hi entries; junk in unused slots; all junk if lo is empty),
// directed frames with hand-computed results, and a scoreboard monitor.
module tb_merge16_scheduler;

  localparam int AB = 11;
  localparam int CB = 3;

  typedef struct {
    logic [8*AB-1:0] adr;
    logic [8*CB-1:0] cnt;
    logic [7:0]      vpf;
    logic [3:0]      ncl;
    logic            trunc;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [32*AB-1:0]  in_adr;
  logic [32*CB-1:0]  in_cnt;
  logic [31:0]       in_vpf;
  logic [8*AB-1:0]   m_adr_lo, m_adr_hi, m_adr_o;
  logic [8*CB-1:0]   m_cnt_lo, m_cnt_hi, m_cnt_o;
  logic [7:0]        m_vpf_lo, m_vpf_hi;
  logic              m_mux_pulse, m_mux_pulse_o;
  logic              out_valid;
  logic [8*AB-1:0]   out_adr;
  logic [8*CB-1:0]   out_cnt;
  logic [7:0]        out_vpf;
  logic [3:0]        out_ncl;
  logic              out_trunc;
  logic [7:0]        drop_cnt;
  logic              err_vpf, err_sync;
  logic              kill;

  merge16_scheduler #(.MXADRBITS(AB), .MXCNTBITS(CB)) dut (
    .clock4x(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_adr(in_adr), .in_cnt(in_cnt), .in_vpf(in_vpf),
    .m_adr_lo(m_adr_lo), .m_adr_hi(m_adr_hi), .m_cnt_lo(m_cnt_lo), .m_cnt_hi(m_cnt_hi),
    .m_vpf_lo(m_vpf_lo), .m_vpf_hi(m_vpf_hi), .m_mux_pulse(m_mux_pulse),
    .m_adr_o(m_adr_o), .m_cnt_o(m_cnt_o), .m_mux_pulse_o(m_mux_pulse_o),
    .out_valid(out_valid), .out_adr(out_adr), .out_cnt(out_cnt), .out_vpf(out_vpf),
    .out_ncl(out_ncl), .out_trunc(out_trunc), .drop_cnt(drop_cnt),
    .err_vpf(err_vpf), .err_sync(err_sync)
  );

  // Merger stub
  logic [8*AB-1:0] mrg_adr, s1_adr = '0, s2_adr = '0;
  logic [8*CB-1:0] mrg_cnt, s1_cnt = '0, s2_cnt = '0;
  logic            s1_p = 1'b0, s2_p = 1'b0;
  int              k_m;

  always_comb begin
    mrg_adr = {8{11'h7FF}};
    mrg_cnt = {8{3'h7}};
    k_m     = 0;
    if (m_vpf_lo[0]) begin
      for (int i = 0; i < 8; i++)
        if (m_vpf_lo[i] && k_m < 8) begin
          mrg_adr[k_m*AB +: AB] = m_adr_lo[i*AB +: AB];
          mrg_cnt[k_m*CB +: CB] = m_cnt_lo[i*CB +: CB];
          k_m = k_m + 1;
        end
      for (int i = 0; i < 8; i++)
        if (m_vpf_hi[i] && k_m < 8) begin
          mrg_adr[k_m*AB +: AB] = m_adr_hi[i*AB +: AB];
          mrg_cnt[k_m*CB +: CB] = m_cnt_hi[i*CB +: CB];
          k_m = k_m + 1;
        end
    end
  end

  always @(posedge clk) begin
    s1_adr <= mrg_adr;
    s1_cnt <= mrg_cnt;
    s1_p   <= m_mux_pulse;
    s2_adr <= s1_adr;
    s2_cnt <= s1_cnt;
    s2_p   <= s1_p;
  end

  assign m_adr_o       = s2_adr;
  assign m_cnt_o       = s2_cnt;
  assign m_mux_pulse_o = s2_p & ~kill;

  // Bookkeeping
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   pulse_cnt = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m_mux_pulse) pulse_cnt++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d required none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_cycle", 128'(cyc), 128'(e.cyc));
        chk("out_adr",   128'(out_adr), 128'(e.adr));
        chk("out_cnt",   128'(out_cnt), 128'(e.cnt));
        chk("out_vpf",   128'(out_vpf), 128'(e.vpf));
        chk("out_ncl",   128'(out_ncl), 128'(e.ncl));
        chk("out_trunc", 128'(out_trunc), 128'(e.trunc));
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got in_ready=0 required 1");
    end
  endtask

  task automatic push_exp(input logic [8*AB-1:0] ea, input logic [8*CB-1:0] ec,
                          input logic [7:0] ev, input logic [3:0] en, input logic et);
    exp_t e;
    e.adr = ea; e.cnt = ec; e.vpf = ev; e.ncl = en; e.trunc = et;
    e.cyc = cyc + 9;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge right after the accept edge.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc,
                      input logic [7:0] vd, input logic push,
                      input logic [8*AB-1:0] ea, input logic [8*CB-1:0] ec,
                      input logic [7:0] ev, input logic [3:0] en, input logic et);
    wait_ready();
    in_vpf   = {vd, vc, vb, va};
    in_valid = 1'b1;
    if (push) push_exp(ea, ec, ev, en, et);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  localparam logic [8*AB-1:0] T1_ADR = {11'h0, 11'h0, 11'h302, 11'h301, 11'h300, 11'h200, 11'h101, 11'h100};
  localparam logic [8*CB-1:0] T1_CNT = {3'd0, 3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd2, 3'd1};
  localparam logic [8*AB-1:0] FA_ADR = {11'h107, 11'h106, 11'h105, 11'h104, 11'h103, 11'h102, 11'h101, 11'h100};
  localparam logic [8*CB-1:0] FA_CNT = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

  int acc[3];
  int nacc;
  int p0;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    kill     = 1'b0;
    in_vpf   = '0;
    for (int g = 0; g < 4; g++)
      for (int s = 0; s < 8; s++) begin
        in_adr[(g*8+s)*AB +: AB] = 11'((g+1)*256 + s);
        in_cnt[(g*8+s)*CB +: CB] = 3'((g+s+1) % 8);
      end

    // Reset state
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_m_mux_pulse", 128'(m_mux_pulse), 128'(0));
    chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    chk("rst_errs", 128'({err_vpf, err_sync}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_in_ready_low", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("rel_in_ready_high", 128'(in_ready), 128'(1));

    // A=2 B=1 C=3 D=0
    p0 = pulse_cnt;
    send(8'h03, 8'h01, 8'h07, 8'h00, 1'b1, T1_ADR, T1_CNT, 8'h3F, 4'd6, 1'b0);
    drain();
    chk("mux_pulses_per_frame", 128'(pulse_cnt - p0), 128'(3));

    // All full
    send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, FA_ADR, FA_CNT, 8'hFF, 4'd8, 1'b1);
    drain();

    // A,B empty, C=1: lo port must carry the non-empty half
    send(8'h00, 8'h00, 8'h01, 8'h00, 1'b1, {{7{11'h0}}, 11'h300}, {{7{3'd0}}, 3'd3},
         8'h01, 4'd1, 1'b0);
    drain();

    // A=1 B=2: B is fuller and goes first
    send(8'h01, 8'h03, 8'h00, 8'h00, 1'b1, {{5{11'h0}}, 11'h100, 11'h201, 11'h200},
         {{5{3'd0}}, 3'd1, 3'd3, 3'd2}, 8'h07, 4'd3, 1'b0);
    drain();

    // in_valid held for 20 cycles
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    nacc = 0;
    wait_ready();
    in_vpf = {8'h00, 8'h07, 8'h01, 8'h03};
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      if (in_ready) begin
        if (nacc < 3) acc[nacc] = i;
        nacc++;
        push_exp(T1_ADR, T1_CNT, 8'h3F, 4'd6, 1'b0);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    chk("stream_accepts", 128'(nacc), 128'(3));
    chk("stream_acc0", 128'(acc[0]), 128'(0));
    chk("stream_acc1", 128'(acc[1]), 128'(9));
    chk("stream_acc2", 128'(acc[2]), 128'(18));
    chk("drop_cnt", 128'(drop_cnt), 128'(17));

    // Return pulse missing at E4; total of exactly 8 is not truncation
    chk("err_sync_before", 128'(err_sync), 128'(0));
    send(8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, FA_ADR, FA_CNT, 8'hFF, 4'd8, 1'b0);
    repeat (3) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    drain();
    chk("err_sync_after", 128'(err_sync), 128'(1));

    // Non-thermometer vpf on A
    chk("err_vpf_before", 128'(err_vpf), 128'(0));
    send(8'b0000_0101, 8'h00, 8'h00, 8'h00, 1'b1, {{7{11'h0}}, 11'h100}, {{7{3'd0}}, 3'd1},
         8'h01, 4'd1, 1'b0);
    drain();
    chk("err_vpf_after", 128'(err_vpf), 128'(1));

    // Reset at E5 abandons the frame
    send(8'h03, 8'h01, 8'h07, 8'h00, 1'b0, '0, '0, 8'h00, 4'd0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    chk("midrst_errs", 128'({err_vpf, err_sync}), 128'(0));
    chk("midrst_drop_cnt", 128'(drop_cnt), 128'(0));
    chk("midrst_out_ncl", 128'(out_ncl), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_rel_low", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("midrst_rel_high", 128'(in_ready), 128'(1));
    repeat (12) @(negedge clk);

    // Recovery frame after reset
    send(8'h03, 8'h01, 8'h07, 8'h00, 1'b1, T1_ADR, T1_CNT, 8'h3F, 4'd6, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/merge16_scheduler.md
Name: merge16_scheduler

Overview:
- Time-multiplexes one shared merge16_light instance on clock4x.
- Reduces four upstream groups of 8 priority-sorted clusters to one group of 8 using three pairwise merges: A+B, then C+D, then AB+CD.
- Tracks valid counts itself, because the merger carries no vpf on its outputs.
- Zero-fills unused output slots, and flags truncation and pipeline desync.

Parameters:
- MXADRBITS, 11, cluster address width.
- MXCNTBITS, 3, cluster size width.

Ports:
- clock4x  in  1  4x LHC clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  frame strobe.
- in_ready  out  1  scheduler idle; a frame is accepted when in_valid & in_ready.
- in_adr  in  32*MXADRBITS  groups A..D (group g, slot s at index g*8+s).
- in_cnt  in  32*MXCNTBITS  same indexing as in_adr.
- in_vpf  in  32  thermometer valid flags, 8 per group.
- m_adr_lo, m_adr_hi  out  8*MXADRBITS each  to merger adr_in0..7 and adr_in8..15.
- m_cnt_lo, m_cnt_hi  out  8*MXCNTBITS each  to merger cnt_in0..7 and cnt_in8..15.
- m_vpf_lo, m_vpf_hi  out  8 each  to merger vpf_in0..7 and vpf_in8..15.
- m_mux_pulse  out  1  issue strobe to merger mux_pulse_in.
- m_adr_o  in  8*MXADRBITS  merger adr0_o..adr7_o.
- m_cnt_o  in  8*MXCNTBITS  merger cnt0_o..cnt7_o.
- m_mux_pulse_o  in  1  merger mux_pulse_out.
- out_valid  out  1  one-cycle result strobe.
- out_adr  out  8*MXADRBITS  merged clusters.
- out_cnt  out  8*MXCNTBITS  merged cluster sizes.
- out_vpf  out  8  thermometer valid flags.
- out_ncl  out  4  number of valid clusters, 0..8.
- out_trunc  out  1  merged total exceeded 8.
- drop_cnt  out  8  saturating count of rejected frames.
- err_vpf  out  1  sticky: non-thermometer input vpf seen.
- err_sync  out  1  sticky: merger return pulse missing.

Behaviour:
- Reset (async, reset_n=0): every output 0, including in_ready; FSM goes to IDLE; all stored groups and counts cleared. in_ready=1 on the first edge after release. Reset mid-sequence abandons the frame; no out_valid is issued for it.
- Group count n = number of leading ones in the group's vpf, starting at bit 0. Any vpf with a 1 above its first 0 sets err_vpf; that group is still processed using n.
- Merge of (L,H): the operand with the larger n goes to the lo port (tie: L stays lo), so an empty lo half never stalls the merger. The issued vpf is the thermometer of the respective n.
- Result count is min(8, nlo+nhi). Result slots at or above the count are forced to 0 in adr and cnt. A count of 0 stores all zeros and ignores merger data.
- FSM, with E0 = the accept edge and one state per clock4x edge:
  - IDLE: on accept, capture in_* and compute nA..nD; go to ISS_AB.
  - ISS_AB (E1): drive A/B onto the m_* registers, m_mux_pulse=1.
  - ISS_CD (E2): drive C/D onto the m_* registers, m_mux_pulse=1.
  - WAIT (E3): no action.
  - CAP_AB (E4): store m_adr_o/m_cnt_o as AB with nAB.
  - CAP_CD (E5): take CD directly from m_adr_o/m_cnt_o with nCD; issue AB vs CD, m_mux_pulse=1.
  - W1 (E6), W2 (E7): no action.
  - CAP_F (E8): load out_* and out_ncl; out_trunc = (nA+nB+nC+nD > 8); out_valid=1; return to IDLE.
- Latency: out_valid is high in the cycle after E8, 8 clocks after accept. Next accept is no earlier than E9.
- m_mux_pulse is low in every state except ISS_AB, ISS_CD and CAP_CD.
- in_ready is low from E0 through E8.
- m_mux_pulse_o must be 1 at the CAP_AB, CAP_CD and CAP_F edges. If it is 0 at any of them, err_sync sets; data is still captured and the sequence continues.
- Outputs hold their values between frames; only out_valid deasserts.
- in_valid while in_ready=0 drops the frame and increments drop_cnt, which saturates at 255. in_valid together with in_ready in the same cycle always accepts.
- err_vpf and err_sync clear only on reset.

Test Plan:
- Counts A=2, B=1, C=3, D=0, distinct addresses -> out_valid at E8+1. out_ncl=6, out_vpf=8'h3F, order A0 A1 B0 C0 C1 C2, slots 6-7 zero, out_trunc=0.
- All groups full (vpf=8'hFF each) -> out = A0..A7, out_ncl=8, out_trunc=1.
- A and B empty, C=1, D=0 -> swap keeps the lo port non-empty. out_ncl=1, out_adr slot0=C0, the rest zero.
- in_valid held high for 20 cycles -> accepts at cycles 0, 9 and 18; drop_cnt=17; outputs match each accepted frame.
- Merger stub suppresses m_mux_pulse_o at E4 -> err_sync=1, out_valid still at E8+1.
- Group A vpf=8'b00000101 -> err_vpf=1 and nA=1. Separately, reset_n pulsed at E5 -> no out_valid, in_ready=1 on the first edge after release.
